alu_insn_sequencer: RTL

Multi-cycle control sequencer for RV32I integer ALU instructions (OP and OP-IMM classes) in the CPU control unit. It is the parametrised successor of the single-cycle R-type decoder. It accepts one instruction through a valid/ready handshake, decodes it into registered control signals and walks it through DECODE, EXEC and WB states. It adds I-type support, illegal-instruction detection, a configurable execute stall and a retired-instruction counter.

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/alu_insn_field_decode.sv | 59 +++++
 rtl/alu_insn_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and the sequencer state type for the ALU
// instruction sequencer and its field decoder.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_insn_field_decode.sv
// Combinational field extraction and legality check for RV32I OP / OP-IMM
// instruction words.
module alu_insn_field_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     insn,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      alu_op,
    output logic            sub_sra,
    output logic            imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];
    assign alu_op = funct3;
    assign imm    = {{(XLEN-12){insn[31]}}, insn[31:20]};

    // Operand select, SUB/SRA flag and legality from opcode, funct3 and funct7
    always_comb begin
        sub_sra = 1'b0;
        imm_sel = 1'b0;
        illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                illegal = !((funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) &&
                             ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
                sub_sra = insn[30];
            end
            OPC_OP_IMM: begin
                imm_sel = 1'b1;
                case (funct3)
                    F3_SLL: illegal = (funct7 != F7_BASE);
                    F3_SRL_SRA: begin
                        illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
                        sub_sra = insn[30];
                    end
                    default: illegal = 1'b0;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_insn_sequencer.sv
// Multi-cycle control sequencer for RV32I OP / OP-IMM instructions:
// accepts one word, decodes it, stalls EXEC_CYCLES in execute, retires in WB.
//
// state  | meaning
// IDLE   | ready for a new instruction word
// DECODE | latched word is decoded; illegal words return to IDLE here
// EXEC   | execute stall, exec_cnt counts down to 1
// WB     | retire: done / rd_we pulse, retired counter advances
//
// All pulses are registered, so illegal is seen in the cycle after DECODE
// (together with insn_ready returning), and done / rd_we are seen during WB.
module alu_insn_sequencer
    import rv32i_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int EXEC_CYCLES = 1,
    parameter int RETIRE_W    = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                insn_valid,
    output logic                insn_ready,
    input  logic [31:0]         INSN,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [2:0]          alu_op,
    output logic                sub_sra,
    output logic                imm_sel,
    output logic [XLEN-1:0]     imm,
    output logic                addr_sel,
    output logic                pc_next_sel,
    output logic                pc_alu_sel,
    output logic                mem_we,
    output logic                rd_we,
    output logic                done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES + 1) : 1;

    seq_state_t      state;
    logic [31:0]     insn_q;
    logic [CNT_W-1:0] exec_cnt;

    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [4:0]      d_rd;
    logic [2:0]      d_alu_op;
    logic            d_sub_sra;
    logic            d_imm_sel;
    logic [XLEN-1:0] d_imm;
    logic            d_illegal;

    alu_insn_field_decode #(.XLEN(XLEN)) u_field_decode (
        .insn    (insn_q),
        .rs1     (d_rs1),
        .rs2     (d_rs2),
        .rd      (d_rd),
        .alu_op  (d_alu_op),
        .sub_sra (d_sub_sra),
        .imm_sel (d_imm_sel),
        .imm     (d_imm),
        .illegal (d_illegal)
    );

    // This instruction class never touches memory or the PC path.
    assign addr_sel    = 1'b0;
    assign pc_next_sel = 1'b0;
    assign pc_alu_sel  = 1'b0;
    assign mem_we      = 1'b0;

    // Sequencer FSM with registered control outputs, pulses and retire counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            insn_q     <= '0;
            exec_cnt   <= '0;
            insn_ready <= 1'b1;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            alu_op     <= '0;
            sub_sra    <= 1'b0;
            imm_sel    <= 1'b0;
            imm        <= '0;
            rd_we      <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            retired    <= '0;
        end else begin
            rd_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (insn_valid && insn_ready) begin
                        insn_q     <= INSN;
                        insn_ready <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (d_illegal) begin
                        illegal    <= 1'b1;
                        insn_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        rs1      <= d_rs1;
                        rs2      <= d_rs2;
                        rd       <= d_rd;
                        alu_op   <= d_alu_op;
                        sub_sra  <= d_sub_sra;
                        imm_sel  <= d_imm_sel;
                        imm      <= d_imm;
                        exec_cnt <= CNT_W'(EXEC_CYCLES);
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    exec_cnt <= exec_cnt - CNT_W'(1);
                    if (exec_cnt == CNT_W'(1)) begin
                        done  <= 1'b1;
                        rd_we <= (rd != 5'd0);
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    retired    <= retired + RETIRE_W'(1);
                    insn_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    insn_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
